// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - CSCv2 sequencer shared constants and types
package pc_sequencer_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_FETCH_OP  = 3'd0;
    localparam logic [2:0] ST_FETCH_ARG = 3'd1;
    localparam logic [2:0] ST_EXEC      = 3'd2;
    localparam logic [2:0] ST_BRANCH    = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    // Jump condition codes carried in opcode[2:0]
    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_N      = 3'd3;
    localparam logic [2:0] COND_NN     = 3'd4;
    localparam logic [2:0] COND_C      = 3'd5;
    localparam logic [2:0] COND_NC     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    // Opcode defaults
    localparam logic [3:0] JMP_CLASS_DEF = 4'hE;
    localparam logic [7:0] HALT_OP_DEF   = 8'hFF;

    // ALU flag bundle as presented on the flags port: {C,N,Z}
    typedef struct packed {
        logic c;
        logic n;
        logic z;
    } alu_flags_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational jump condition resolver
module cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    alu_flags_t f;
    assign f = alu_flags_t'(flags);

    // Map the 3-bit condition code onto the sampled ALU flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = f.z;
            COND_NZ:     taken = ~f.z;
            COND_N:      taken = f.n;
            COND_NN:     taken = ~f.n;
            COND_C:      taken = f.c;
            COND_NC:     taken = ~f.c;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - CSCv2 fetch/execute sequencer driving the program counter
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [3:0]        JMP_CLASS = JMP_CLASS_DEF,
    parameter logic [DATA_W-1:0] HALT_OP   = DATA_W'(HALT_OP_DEF),
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic [2:0]        flags,
    input  logic              exec_done,
    input  logic              run,
    output logic              mem_req,
    output logic              pc_incr,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_data,
    output logic [DATA_W-1:0] ir_op,
    output logic [DATA_W-1:0] ir_arg,
    output logic              exec_start,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q,       state_d;
    logic              mem_req_q,     mem_req_d;
    logic              pc_incr_q,     pc_incr_d;
    logic              pc_load_q,     pc_load_d;
    logic              exec_start_q,  exec_start_d;
    logic              halted_q,      halted_d;
    logic [DATA_W-1:0] ir_op_q,       ir_op_d;
    logic [DATA_W-1:0] ir_arg_q,      ir_arg_d;
    logic [DATA_W-1:0] pc_data_q,     pc_data_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;

    logic accept;
    logic is_jump;
    logic taken;

    // An edge accepts a byte only while a request is already on the port
    assign accept  = mem_req_q & mem_ready;
    assign is_jump = (ir_op_q[7:4] == JMP_CLASS);

    cond_eval u_cond_eval (
        .flags (flags),
        .cond  (ir_op_q[2:0]),
        .taken (taken)
    );

    // Next-state and registered-output logic; every pulse lasts one cycle
    always_comb begin
        state_d       = state_q;
        mem_req_d     = 1'b0;
        pc_incr_d     = 1'b0;
        pc_load_d     = 1'b0;
        exec_start_d  = 1'b0;
        halted_d      = halted_q;
        ir_op_d       = ir_op_q;
        ir_arg_d      = ir_arg_q;
        pc_data_d     = pc_data_q;
        instr_count_d = instr_count_q;

        case (state_q)
            ST_FETCH_OP: begin
                // Entry cycle has mem_req low so the PC can settle
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (accept) begin
                    ir_op_d   = mem_data;
                    pc_incr_d = 1'b1;
                    if (mem_data == HALT_OP) begin
                        state_d       = ST_HALT;
                        halted_d      = 1'b1;
                        instr_count_d = instr_count_q + CNT_ONE;
                    end else begin
                        state_d = ST_FETCH_ARG;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            ST_FETCH_ARG: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (accept) begin
                    ir_arg_d  = mem_data;
                    pc_data_d = mem_data;
                    if (is_jump && taken) begin
                        state_d   = ST_BRANCH;
                        pc_load_d = 1'b1;
                    end else if (is_jump) begin
                        state_d       = ST_FETCH_OP;
                        pc_incr_d     = 1'b1;
                        instr_count_d = instr_count_q + CNT_ONE;
                    end else begin
                        state_d      = ST_EXEC;
                        pc_incr_d    = 1'b1;
                        exec_start_d = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            ST_EXEC: begin
                // exec_done is ignored during the exec_start cycle itself
                if (!exec_start_q && exec_done) begin
                    state_d       = ST_FETCH_OP;
                    instr_count_d = instr_count_q + CNT_ONE;
                end
            end

            ST_BRANCH: begin
                state_d       = ST_FETCH_OP;
                instr_count_d = instr_count_q + CNT_ONE;
            end

            ST_HALT: begin
                if (run) begin
                    state_d  = ST_FETCH_OP;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d  = ST_FETCH_OP;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FETCH_OP;
            mem_req_q     <= 1'b0;
            pc_incr_q     <= 1'b0;
            pc_load_q     <= 1'b0;
            exec_start_q  <= 1'b0;
            halted_q      <= 1'b0;
            ir_op_q       <= '0;
            ir_arg_q      <= '0;
            pc_data_q     <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            pc_incr_q     <= pc_incr_d;
            pc_load_q     <= pc_load_d;
            exec_start_q  <= exec_start_d;
            halted_q      <= halted_d;
            ir_op_q       <= ir_op_d;
            ir_arg_q      <= ir_arg_d;
            pc_data_q     <= pc_data_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign pc_incr     = pc_incr_q;
    assign pc_load     = pc_load_q;
    assign pc_data     = pc_data_q;
    assign ir_op       = ir_op_q;
    assign ir_arg      = ir_arg_q;
    assign exec_start  = exec_start_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              mem_ready = 1'b0;
    logic [2:0]        flags = 3'b000;
    logic              exec_done = 1'b0;
    logic              run = 1'b0;
    logic              mem_req, pc_incr, pc_load, exec_start, halted;
    logic [DATA_W-1:0] pc_data, ir_op, ir_arg;
    logic [CNT_W-1:0]  instr_count;

    logic [2:0] ce_flags = 3'b000;
    logic [2:0] ce_cond  = 3'b000;
    logic       ce_taken;

    int n_vec  = 0;
    int n_miss = 0;

    int n_incr = 0, n_load = 0, n_exec = 0, viol = 0;
    logic prev_incr = 1'b0, prev_load = 1'b0, prev_exec = 1'b0;
    logic [DATA_W-1:0] last_load_data = '0;

    pc_sequencer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .flags       (flags),
        .exec_done   (exec_done),
        .run         (run),
        .mem_req     (mem_req),
        .pc_incr     (pc_incr),
        .pc_load     (pc_load),
        .pc_data     (pc_data),
        .ir_op       (ir_op),
        .ir_arg      (ir_arg),
        .exec_start  (exec_start),
        .halted      (halted),
        .instr_count (instr_count)
    );

    cond_eval u_ce (
        .flags (ce_flags),
        .cond  (ce_cond),
        .taken (ce_taken)
    );

    always #5 clk = ~clk;

    // Per-cycle pulse counting and protocol rules, sampled just after each edge
    always @(posedge clk) begin
        #1;
        n_incr    <= n_incr + (pc_incr ? 1 : 0);
        n_load    <= n_load + (pc_load ? 1 : 0);
        n_exec    <= n_exec + (exec_start ? 1 : 0);
        if (pc_load) last_load_data <= pc_data;
        if ((pc_incr && pc_load) || ((pc_incr || pc_load) && mem_req) ||
            (pc_incr && prev_incr) || (pc_load && prev_load) || (exec_start && prev_exec) ||
            (halted && (mem_req || pc_load || exec_start)))
            viol <= viol + 1;
        prev_incr <= pc_incr;
        prev_load <= pc_load;
        prev_exec <= exec_start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] arg;
        logic [2:0] flg;
        logic [1:0] exp_incr;
        logic       exp_load;
        logic       exp_exec;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f, input logic [2:0] c);
        logic z, n, cy;
        z = f[0]; n = f[1]; cy = f[2];
        if (c == 3'd0) return 1'b1;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z;
        if (c == 3'd3) return n;
        if (c == 3'd4) return !n;
        if (c == 3'd5) return cy;
        if (c == 3'd6) return !cy;
        return 1'b0;
    endfunction

    // Wait (bounded) for mem_req at a falling edge
    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " mem_req_seen"}, 32'(mem_req), 32'd1);
    endtask

    // Serve one byte; hold mem_ready low for `delay` cycles first
    task automatic fetch_byte(input logic [7:0] b, input int delay, input string tag);
        int bad = 0;
        logic [7:0] op0, arg0;
        wait_req(tag);
        op0 = ir_op;
        arg0 = ir_arg;
        for (int i = 0; i < delay; i++) begin
            mem_data = 8'h77;
            @(negedge clk);
            if (mem_req !== 1'b1 || ir_op !== op0 || ir_arg !== arg0) bad++;
        end
        if (delay > 0) chk({tag, " hold_while_not_ready"}, 32'(bad), 32'd0);
        mem_data  = b;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_data  = 8'hC3;
    endtask

    // Called at the falling edge of the exec_start cycle
    task automatic finish_exec(input string tag);
        chk({tag, " exec_start"}, 32'(exec_start), 32'd1);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        @(negedge clk);
        chk({tag, " early_done_ignored"}, 32'(mem_req), 32'd0);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
    endtask

    task automatic do_instr(input vec_t v, input string tag);
        int i0, l0, e0;
        logic [CNT_W-1:0] c0;
        wait_req(tag);
        i0 = n_incr; l0 = n_load; e0 = n_exec; c0 = instr_count;
        flags = v.flg;
        fetch_byte(v.op, 0, tag);
        fetch_byte(v.arg, 0, tag);
        if (v.exp_exec) finish_exec(tag);
        wait_req(tag);
        chk({tag, " ir_op"}, 32'(ir_op), 32'(v.op));
        chk({tag, " ir_arg"}, 32'(ir_arg), 32'(v.arg));
        chk({tag, " pc_incr_count"}, 32'(n_incr - i0), 32'(v.exp_incr));
        chk({tag, " pc_load_count"}, 32'(n_load - l0), 32'(v.exp_load));
        chk({tag, " exec_start_count"}, 32'(n_exec - e0), 32'(v.exp_exec));
        chk({tag, " instr_count"}, 32'(instr_count), 32'(c0 + 16'd1));
        if (v.exp_load) chk({tag, " pc_data"}, 32'(last_load_data), 32'(v.arg));
    endtask

    initial begin
        int bad;
        int i0;
        logic [CNT_W-1:0] c0;
        vec_t v;

        vecs[0]  = {8'h12, 8'h34, 3'b000, 2'd2, 1'b0, 1'b1};
        vecs[1]  = {8'hE1, 8'h40, 3'b001, 2'd1, 1'b1, 1'b0};
        vecs[2]  = {8'hE1, 8'h40, 3'b000, 2'd2, 1'b0, 1'b0};
        vecs[3]  = {8'hE2, 8'h41, 3'b000, 2'd1, 1'b1, 1'b0};
        vecs[4]  = {8'hE2, 8'h42, 3'b001, 2'd2, 1'b0, 1'b0};
        vecs[5]  = {8'hE3, 8'h43, 3'b010, 2'd1, 1'b1, 1'b0};
        vecs[6]  = {8'hE4, 8'h44, 3'b010, 2'd2, 1'b0, 1'b0};
        vecs[7]  = {8'hE4, 8'h45, 3'b101, 2'd1, 1'b1, 1'b0};
        vecs[8]  = {8'hE5, 8'h46, 3'b100, 2'd1, 1'b1, 1'b0};
        vecs[9]  = {8'hE6, 8'h47, 3'b100, 2'd2, 1'b0, 1'b0};
        vecs[10] = {8'h7E, 8'h55, 3'b111, 2'd2, 1'b0, 1'b1};
        vecs[11] = {8'hD1, 8'h66, 3'b001, 2'd2, 1'b0, 1'b1};

        // Reset state
        @(negedge clk);
        chk("reset outputs",
            32'({mem_req, pc_incr, pc_load, exec_start, halted, ir_op, ir_arg, pc_data}), 32'd0);
        chk("reset instr_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first cycle mem_req", 32'(mem_req), 32'd1);

        // Table of single-instruction vectors
        for (int k = 0; k < 12; k++) begin
            do_instr(vecs[k], $sformatf("vec%0d", k));
        end

        // Always / never jumps across every flag value
        for (int f = 0; f < 8; f++) begin
            v = {8'hE0, 8'(8'h20 + f), 3'(f), 2'd1, 1'b1, 1'b0};
            do_instr(v, $sformatf("E0 f%0d", f));
            v = {8'hE7, 8'(8'h30 + f), 3'(f), 2'd2, 1'b0, 1'b0};
            do_instr(v, $sformatf("E7 f%0d", f));
        end

        // HALT and restart
        wait_req("halt");
        c0 = instr_count;
        i0 = n_incr;
        fetch_byte(8'hFF, 0, "halt");
        chk("halt halted", 32'(halted), 32'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("halt mem_req_quiet", 32'(bad), 32'd0);
        chk("halt pc_incr_count", 32'(n_incr - i0), 32'd1);
        chk("halt instr_count", 32'(instr_count), 32'(c0 + 16'd1));
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("run halted_clear", 32'(halted), 32'd0);
        wait_req("resume");

        // Slow memory, plus a ready pulse while no request is pending
        fetch_byte(8'h5A, 7, "slow op");
        chk("slow ir_op", 32'(ir_op), 32'h5A);
        chk("arg settle mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        mem_data  = 8'h99;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("stray ready ignored", 32'(ir_arg), 32'h30 + 32'd7);
        fetch_byte(8'hA5, 2, "slow arg");
        finish_exec("slow");
        wait_req("slow done");
        chk("slow ir_arg", 32'(ir_arg), 32'hA5);

        // Asynchronous reset during EXEC
        fetch_byte(8'h12, 0, "rst exec");
        fetch_byte(8'h34, 0, "rst exec");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst exec outputs",
            32'({mem_req, pc_incr, pc_load, exec_start, halted, ir_op, ir_arg, pc_data}), 32'd0);
        chk("rst exec instr_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_req("rst exec restart");

        // Asynchronous reset while mem_req is high mid-fetch
        fetch_byte(8'h21, 0, "rst fetch");
        wait_req("rst fetch arg");
        reset_n = 1'b0;
        #1;
        chk("rst fetch outputs",
            32'({mem_req, pc_incr, pc_load, exec_start, halted, ir_op, ir_arg, pc_data}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst fetch restart mem_req", 32'(mem_req), 32'd1);
        chk("rst fetch instr_count", 32'(instr_count), 32'd0);

        // Exhaustive condition evaluator check
        for (int k = 0; k < 64; k++) begin
            ce_flags = 3'(k >> 3);
            ce_cond  = 3'(k);
            #1;
            chk($sformatf("cond f%0d c%0d", k >> 3, k & 7), 32'(ce_taken),
                32'(ref_taken(ce_flags, ce_cond)));
        end

        @(negedge clk);
        chk("protocol rules", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute sequencer for the CSCv2 program counter.
- Reads two-byte instructions (opcode, operand) over a ready-handshake memory port.
- Drives one-cycle increment/load pulses to the PC.
- Resolves conditional jumps against ALU flags, hands non-jump instructions to the execute unit, and stops on a HALT opcode until restarted.

Parameters:
DATA_W, 8, opcode/operand/PC width
JMP_CLASS, 4'hE, opcode[7:4] value marking a jump; opcode[2:0] is the condition
HALT_OP, 8'hFF, single-byte halt opcode
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_data  in  DATA_W  byte read at current PC
mem_ready  in  1  mem_data valid; sampled only while mem_req=1
flags  in  3  {C,N,Z} from ALU, sampled at jump decision edge
exec_done  in  1  execute unit finished current instruction
run  in  1  restart pulse, honoured only in HALT
mem_req  out  1  fetch request at current PC
pc_incr  out  1  PC increment pulse
pc_load  out  1  PC load pulse (loads pc_data)
pc_data  out  DATA_W  jump target (= ir_arg)
ir_op  out  DATA_W  latched opcode
ir_arg  out  DATA_W  latched operand
exec_start  out  1  one-cycle start pulse to execute unit
halted  out  1  high in HALT
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, reset_n=0):
  - state=FETCH_OP, entry sub-cycle.
  - All outputs 0: mem_req, pc_incr, pc_load, exec_start, halted, ir_op, ir_arg, pc_data, instr_count.
  - mem_req drops immediately, also mid-handshake. Any in-flight fetch or exec is abandoned; no pulse is emitted.
- All outputs are registered. No combinational input-to-output path.
- States: FETCH_OP, FETCH_ARG, EXEC, BRANCH, HALT.
- FETCH_OP / FETCH_ARG:
  - First cycle in the state has mem_req=0 (PC settle). mem_req=1 from the next cycle until accepted.
  - Acceptance is an edge with mem_req=1 and mem_ready=1. mem_req=0 in the following cycle.
  - mem_ready while mem_req=0 is ignored.
- FETCH_OP accept:
  - ir_op<=mem_data; pc_incr=1 next cycle.
  - If mem_data==HALT_OP: go to HALT, halted=1, instr_count+1.
  - Otherwise go to FETCH_ARG.
- FETCH_ARG accept: ir_arg<=mem_data and pc_data<=mem_data, then:
  - Jump (ir_op[7:4]==JMP_CLASS), condition true: go to BRANCH, pc_load=1 next cycle, pc_incr=0.
  - Jump, condition false: pc_incr=1, go to FETCH_OP, instr_count+1.
  - Non-jump: pc_incr=1 and exec_start=1 next cycle, go to EXEC.
- Condition codes (opcode[2:0]), using flags sampled on the accept edge:
  - 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 !C, 7 never.
- BRANCH: one cycle (pc_load high), then FETCH_OP; instr_count+1.
- EXEC:
  - exec_done is sampled from the cycle after exec_start. exec_done in the exec_start cycle is ignored.
  - On exec_done: go to FETCH_OP, instr_count+1. No timeout.
- HALT: holds, with outputs other than halted deasserted. run=1 leads to FETCH_OP with halted=0 on the next edge.
- pc_incr and pc_load are never high in the same cycle, and each is at most one cycle wide.
- A pc pulse is never in the same cycle as mem_req=1.
- Minimum latency:
  - Non-jump: 5 cycles + exec wait.
  - Not-taken jump: 5 cycles.
  - Taken jump: 6 cycles.
- instr_count wraps from all-ones to 0.

Decomposition:
- Shared CSCv2 package holds:
  - state encoding constants (FETCH_OP=0, FETCH_ARG=1, EXEC=2, BRANCH=3, HALT=4);
  - condition code constants COND_ALWAYS..COND_NEVER;
  - JMP_CLASS and HALT_OP defaults.
- One sub-module, cond_eval: combinational {flags, cond[2:0]} -> taken.
- FSM, IR latches and counter stay in pc_sequencer.

Test Plan:
- Reset, then memory returns ready the cycle after each mem_req, with bytes 8'h12, 8'h34 and exec_done 2 cycles after exec_start:
  - ir_op=12 and ir_arg=34.
  - Two pc_incr pulses, one exec_start.
  - instr_count=1; back in FETCH_OP.
- Jump 8'hE1 (JZ), operand 8'h40:
  - flags=3'b001: pc_load pulse with pc_data=40, no pc_incr after the operand, no exec_start.
  - Repeat with flags=3'b000: pc_incr instead, no pc_load.
- Opcodes E0 (always) and E7 (never) with all 8 flag values: taken for every flag value with E0, never taken with E7.
  - Also check cond_eval for all 64 combinations against a reference model.
- Fetch 8'hFF: one pc_incr, halted=1, mem_req stays 0 for 10 cycles. Pulse run: halted=0, fetch resumes.
- Hold mem_ready=0 for 7 cycles, then 1: mem_req is held throughout; ir_op captures only on the ready cycle.
  - mem_ready pulses while mem_req=0 are ignored.
- Assert reset_n=0 in EXEC and mid-fetch with mem_req=1: all outputs go to 0 asynchronously, before the next edge.
  - instr_count=0; FETCH_OP restarts after release.
